piso_serializer: RTL and testbench

- Parallel-in, serial-out stage that sits directly upstream of the SISO/SIPO shift registers and drives their data_in.
- Accepts a WIDTH-bit word through a valid/ready handshake and emits it one bit per enabled clock on ser_out.
- Marks the first and last bit of each frame so downstream logic can align to word boundaries.
- Supports back-to-back words with no idle bit between frames.

---
 rtl/piso_serializer_if.sv | 24 ++
 rtl/piso_serializer.sv | 96 +++++++++
 tb/tb_piso_serializer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/piso_serializer_if.sv
// Handshake and serial-output bundle between a word source and piso_serializer.
interface piso_if #(
    parameter int WIDTH = 4
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             shift_en;
    logic             ser_out;
    logic             ser_valid;
    logic             frame_start;
    logic             frame_last;
    logic             busy;

    modport master (
        output load_valid, load_data, shift_en,
        input  load_ready, ser_out, ser_valid, frame_start, frame_last, busy
    );

    modport slave (
        input  load_valid, load_data, shift_en,
        output load_ready, ser_out, ser_valid, frame_start, frame_last, busy
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage: takes a WIDTH-bit word over valid/ready and
// emits it one bit per enabled clock with frame start/last markers.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic  clk,
    input  logic  rst,
    piso_if.slave bus
);
    localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_p0, state_nxt;
    logic [WIDTH-1:0] shreg_p0, shreg_nxt;
    logic [CW-1:0]    cnt_p0, cnt_nxt;
    logic             in_shift;
    logic             at_last;
    logic             load_ready_c;
    logic             accept;

    // Moves the register one place toward whichever end drives ser_out.
    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
        if (MSB_FIRST) begin
            return {v[WIDTH-2:0], 1'b0};
        end else begin
            return {1'b0, v[WIDTH-1:1]};
        end
    endfunction

    assign in_shift     = (state_p0 == SHIFT);
    assign at_last      = in_shift && (cnt_p0 == LAST_IDX);
    assign load_ready_c = !rst && (!in_shift || (at_last && bus.shift_en));
    assign accept       = bus.load_valid && load_ready_c;

    always_comb begin
        state_nxt = state_p0;
        shreg_nxt = shreg_p0;
        cnt_nxt   = cnt_p0;
        unique case (state_p0)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                    shreg_nxt = bus.load_data;
                    cnt_nxt   = '0;
                end
            end
            SHIFT: begin
                if (accept) begin
                    shreg_nxt = bus.load_data;
                    cnt_nxt   = '0;
                end else if (bus.shift_en) begin
                    if (at_last) begin
                        // Clearing here keeps ser_out low while idle.
                        state_nxt = IDLE;
                        shreg_nxt = '0;
                        cnt_nxt   = '0;
                    end else begin
                        shreg_nxt = shift_once(shreg_p0);
                        cnt_nxt   = cnt_p0 + CW'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                shreg_nxt = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Stage p0: state, shift register and bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0 <= IDLE;
            shreg_p0 <= '0;
            cnt_p0   <= '0;
        end else begin
            state_p0 <= state_nxt;
            shreg_p0 <= shreg_nxt;
            cnt_p0   <= cnt_nxt;
        end
    end

    assign bus.ser_out     = MSB_FIRST ? shreg_p0[WIDTH-1] : shreg_p0[0];
    assign bus.ser_valid   = in_shift;
    assign bus.busy        = in_shift;
    assign bus.frame_start = in_shift && (cnt_p0 == '0);
    assign bus.frame_last  = at_last;
    assign bus.load_ready  = load_ready_c;
endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share stimulus
// and are compared each cycle against a queue of expected frame bits.
module tb_piso_serializer;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_valid;
    logic [W-1:0] load_data;
    logic         shift_en;
    int           checks = 0;
    int           errors = 0;
    bit           chk_on = 1'b0;

    typedef struct packed {
        logic bm;
        logic bl;
        logic s;
        logic l;
    } ent_t;

    ent_t q[$];

    piso_if #(.WIDTH(W)) bm ();
    piso_if #(.WIDTH(W)) bl ();

    assign bm.load_valid = load_valid;
    assign bm.load_data  = load_data;
    assign bm.shift_en   = shift_en;
    assign bl.load_valid = load_valid;
    assign bl.load_data  = load_data;
    assign bl.shift_en   = shift_en;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(bm));
    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bl));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: each accepted word becomes W queued bits; a consumed bit pops one.
    always @(posedge clk) begin
        bit acc;
        acc = load_valid && !rst && (q.size() == 0 || (q.size() == 1 && shift_en));
        if (rst) begin
            q.delete();
        end else begin
            if (shift_en && q.size() > 0) void'(q.pop_front());
            if (acc) begin
                for (int k = 0; k < W; k++) begin
                    q.push_back('{bm: load_data[W-1-k], bl: load_data[k],
                                  s: (k == 0), l: (k == W-1)});
                end
            end
        end
    end

    always @(negedge clk) begin
        ent_t e;
        bit   v;
        bit   er;
        if (chk_on) begin
            v  = (q.size() > 0);
            e  = '0;
            if (v) e = q[0];
            er = !rst && (q.size() == 0 || (q.size() == 1 && shift_en));
            check("m_ser_valid",   32'(bm.ser_valid),   32'(v));
            check("m_busy",        32'(bm.busy),        32'(v));
            check("m_ser_out",     32'(bm.ser_out),     32'(e.bm));
            check("m_frame_start", 32'(bm.frame_start), 32'(e.s));
            check("m_frame_last",  32'(bm.frame_last),  32'(e.l));
            check("m_load_ready",  32'(bm.load_ready),  32'(er));
            check("l_ser_valid",   32'(bl.ser_valid),   32'(v));
            check("l_busy",        32'(bl.busy),        32'(v));
            check("l_ser_out",     32'(bl.ser_out),     32'(e.bl));
            check("l_frame_start", 32'(bl.frame_start), 32'(e.s));
            check("l_frame_last",  32'(bl.frame_last),  32'(e.l));
            check("l_load_ready",  32'(bl.load_ready),  32'(er));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] word;
        logic [W-1:0] sipo;
        logic [7:0]   seq;

        rst = 1'b1; load_valid = 1'b1; load_data = 4'hF; shift_en = 1'b1;

        // Reset held with load_valid asserted
        tick();
        chk_on = 1'b1;
        @(negedge clk);
        check("rst_ready",     32'(bm.load_ready),  32'(0));
        check("rst_ser_valid", 32'(bm.ser_valid),   32'(0));
        check("rst_ser_out",   32'(bm.ser_out),     32'(0));
        check("rst_start",     32'(bm.frame_start), 32'(0));
        check("rst_last",      32'(bm.frame_last),  32'(0));
        check("rst_busy",      32'(bm.busy),        32'(0));
        tick();
        @(negedge clk);
        check("rst_ready2", 32'(bm.load_ready), 32'(0));
        tick();
        rst = 1'b0; load_valid = 1'b0;
        @(negedge clk);
        check("rel_ready", 32'(bm.load_ready), 32'(1));

        // Single word 1011, MSB first, into a SIPO
        load_valid = 1'b1; load_data = 4'b1011;
        tick();
        load_valid = 1'b0;
        word = 4'b1011; sipo = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2_bit",   32'(bm.ser_out),     32'(word[3-i]));
            check("t2_start", 32'(bm.frame_start), 32'(i == 0));
            check("t2_last",  32'(bm.frame_last),  32'(i == 3));
            sipo = {sipo[W-2:0], bm.ser_out};
            tick();
        end
        @(negedge clk);
        check("t2_idle", 32'(bm.ser_valid), 32'(0));
        check("t2_sipo", 32'(sipo),         32'(4'b1011));

        // Back-to-back A then 5
        seq = 8'b1010_0101;
        load_valid = 1'b1; load_data = 4'hA;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                load_valid = 1'b1; load_data = 4'h5;
            end
            @(negedge clk);
            check("t3_valid", 32'(bm.ser_valid),   32'(1));
            check("t3_bit",   32'(bm.ser_out),     32'(seq[7-i]));
            check("t3_start", 32'(bm.frame_start), 32'(i == 0 || i == 4));
            if (i == 3) check("t3_ready", 32'(bm.load_ready), 32'(1));
            tick();
            if (i == 3) load_valid = 1'b0;
        end
        @(negedge clk);
        check("t3_idle", 32'(bm.ser_valid), 32'(0));

        // Stall on the 2nd bit of 1100
        load_valid = 1'b1; load_data = 4'b1100;
        tick();
        load_valid = 1'b0;
        @(negedge clk);
        check("t4_b0", 32'(bm.ser_out), 32'(1));
        tick();
        shift_en = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check("t4_hold",  32'(bm.ser_out),     32'(1));
            check("t4_start", 32'(bm.frame_start), 32'(0));
            check("t4_last",  32'(bm.frame_last),  32'(0));
            check("t4_ready", 32'(bm.load_ready),  32'(0));
            tick();
        end
        shift_en = 1'b1;
        @(negedge clk);
        check("t4_b1", 32'(bm.ser_out), 32'(1));
        tick();
        @(negedge clk);
        check("t4_b2",    32'(bm.ser_out),    32'(0));
        check("t4_last2", 32'(bm.frame_last), 32'(0));
        tick();
        @(negedge clk);
        check("t4_b3",    32'(bm.ser_out),    32'(0));
        check("t4_last3", 32'(bm.frame_last), 32'(1));
        tick();

        // LSB first, 0001
        load_valid = 1'b1; load_data = 4'b0001;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t5_bit", 32'(bl.ser_out), 32'(i == 0));
            tick();
        end

        // Reset in the middle of F, then 3
        load_valid = 1'b1; load_data = 4'hF;
        tick();
        load_valid = 1'b0;
        @(negedge clk);
        check("t6_b0", 32'(bm.ser_out), 32'(1));
        tick();
        @(negedge clk);
        check("t6_b1", 32'(bm.ser_out), 32'(1));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t6_valid", 32'(bm.ser_valid), 32'(0));
        check("t6_out",   32'(bm.ser_out),   32'(0));
        load_valid = 1'b1; load_data = 4'h3;
        tick();
        load_valid = 1'b0;
        word = 4'h3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t6_bit", 32'(bm.ser_out), 32'(word[3-i]));
            tick();
        end

        // Randomized traffic; the first stretch keeps shift_en high for back-to-back frames
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 63) == 0);
            load_valid = ($urandom_range(0, 3) != 0);
            load_data  = W'($urandom);
            shift_en   = (c < 1000) ? 1'b1 : ($urandom_range(0, 3) != 0);
            tick();
        end
        rst = 1'b0; load_valid = 1'b0; shift_en = 1'b1;
        repeat (8) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
